control_unit: RTL and testbench

- Hardwired Mini SRC control sequencer.
- Drives every control input of DataPath: one T-step per Clock, fetch → decode → execute, then back to fetch.
- Replaces the hand-coded testbench state sequencing and is instantiated beside DataPath in the top-level CPU.
- Decodes the 32-bit IR and samples CON_FF to decide branches.

---
 rtl/control_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Hardwired Mini SRC control sequencer. It steps through one T-state per
// Clock: fetch (T0-T2), decode, then the execute steps for the opcode in
// IR[31:27]. After the last step it returns to T0, or goes to HALT when Stop
// is high. Every control input of DataPath is driven from here.
//
// Ports:
//   Clock          rising-edge system clock
//   Clear          asynchronous, active-high reset (forces RST at once)
//   IR             instruction register contents (opcode in the top OPW bits)
//   CON_FF         branch condition flip-flop, only looked at in T6 of br
//   Stop           halt request, acted on only at the end of an instruction
//   Run            high in T0-T7
//   PCout..Cout    bus driver enables
//   MARin..R15in   register load enables
//   Gra..Rout      select-and-encode controls
//   IncPC, Read, Write
//   ADD..NOT       ALU operation selects, one-hot or all zero
// ----------------------------------------------------------------------------
module control_unit #(
   parameter int OPW = 5
) (
   input  logic        Clock,
   input  logic        Clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        Run,
   output logic        PCout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        MDRout,
   output logic        HIout,
   output logic        LOout,
   output logic        InPortout,
   output logic        BAout,
   output logic        Cout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        LOin,
   output logic        HIin,
   output logic        CONin,
   output logic        OutPortIn,
   output logic        R15in,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        Rin,
   output logic        Rout,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        SHR,
   output logic        SHRA,
   output logic        SHL,
   output logic        ROR,
   output logic        ROL,
   output logic        MUL,
   output logic        DIV,
   output logic        NEG,
   output logic        NOT
);

   typedef enum logic [3:0] {
      RST  = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7,
      T7   = 4'd8,
      HALT = 4'd9
   } state_t;

   localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
   localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
   localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
   localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
   localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
   localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
   localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b01000);
   localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01001);
   localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01010);
   localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01011);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
   localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
   localparam logic [OPW-1:0] OP_BR   = OPW'(5'b10011);
   localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10101);
   localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
   localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
   localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
   localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
   localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

   state_t           state;
   state_t           last_step;
   logic [OPW-1:0]   opcode;
   logic             unused_ir_bits;

   assign opcode         = IR[31 -: OPW];
   assign unused_ir_bits = ^IR[31-OPW:0];

   // Final T-step of each instruction class. nop, halt and any undefined
   // opcode end with fetch, so their last step is T2.
   always_comb begin
      last_step = T2;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
         OP_ROL, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:
            last_step = T5;
         OP_LD, OP_ST:
            last_step = T7;
         OP_MUL, OP_DIV, OP_BR:
            last_step = T6;
         OP_NEG, OP_NOT, OP_JAL:
            last_step = T4;
         OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:
            last_step = T3;
         OP_NOP, OP_HALT:
            last_step = T2;
         default:
            last_step = T2;
      endcase
   end

   // Step sequencer. Clear drops straight into RST from any step. Stop is
   // only looked at on the edge that ends an instruction, so an instruction
   // always runs to completion. The halt opcode leaves fetch directly for
   // HALT, which is only left again through Clear.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state <= RST;
      end else begin
         case (state)
            RST:  state <= T0;
            T0:   state <= T1;
            T1:   state <= T2;
            T2: begin
               if (opcode == OP_HALT)
                  state <= HALT;
               else if (last_step == T2)
                  state <= Stop ? HALT : T0;
               else
                  state <= T3;
            end
            T3: begin
               if (last_step == T3)
                  state <= Stop ? HALT : T0;
               else
                  state <= T4;
            end
            T4: begin
               if (last_step == T4)
                  state <= Stop ? HALT : T0;
               else
                  state <= T5;
            end
            T5: begin
               if (last_step == T5)
                  state <= Stop ? HALT : T0;
               else
                  state <= T6;
            end
            T6: begin
               if (last_step == T6)
                  state <= Stop ? HALT : T0;
               else
                  state <= T7;
            end
            T7:   state <= Stop ? HALT : T0;
            HALT: state <= HALT;
            default: state <= RST;
         endcase
      end
   end

   // Control decode. Fetch steps do not depend on IR; execute steps decode
   // the opcode. RST and HALT leave everything low. CON_FF is folded in
   // combinationally in T6 of br so the branch target is loaded only when
   // the condition holds.
   always_comb begin
      Run       = 1'b0;
      PCout     = 1'b0;
      Zlowout   = 1'b0;
      Zhighout  = 1'b0;
      MDRout    = 1'b0;
      HIout     = 1'b0;
      LOout     = 1'b0;
      InPortout = 1'b0;
      BAout     = 1'b0;
      Cout      = 1'b0;
      MARin     = 1'b0;
      Zin       = 1'b0;
      PCin      = 1'b0;
      MDRin     = 1'b0;
      IRin      = 1'b0;
      Yin       = 1'b0;
      LOin      = 1'b0;
      HIin      = 1'b0;
      CONin     = 1'b0;
      OutPortIn = 1'b0;
      R15in     = 1'b0;
      Gra       = 1'b0;
      Grb       = 1'b0;
      Grc       = 1'b0;
      Rin       = 1'b0;
      Rout      = 1'b0;
      IncPC     = 1'b0;
      Read      = 1'b0;
      Write     = 1'b0;
      ADD       = 1'b0;
      SUB       = 1'b0;
      AND       = 1'b0;
      OR        = 1'b0;
      SHR       = 1'b0;
      SHRA      = 1'b0;
      SHL       = 1'b0;
      ROR       = 1'b0;
      ROL       = 1'b0;
      MUL       = 1'b0;
      DIV       = 1'b0;
      NEG       = 1'b0;
      NOT       = 1'b0;

      case (state)
         T0: begin
            Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
         end
         T1: begin
            Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
         end
         T2: begin
            Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
         end
         T3, T4, T5, T6, T7: begin
            Run = 1'b1;
            case (opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
               OP_ROR, OP_ROL: begin
                  case (state)
                     T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                     T4: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        case (opcode)
                           OP_ADD:  ADD  = 1'b1;
                           OP_SUB:  SUB  = 1'b1;
                           OP_AND:  AND  = 1'b1;
                           OP_OR:   OR   = 1'b1;
                           OP_SHR:  SHR  = 1'b1;
                           OP_SHRA: SHRA = 1'b1;
                           OP_SHL:  SHL  = 1'b1;
                           OP_ROR:  ROR  = 1'b1;
                           OP_ROL:  ROL  = 1'b1;
                           default: ;
                        endcase
                     end
                     T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_ADDI, OP_ANDI, OP_ORI: begin
                  case (state)
                     T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                     T4: begin
                        Cout = 1'b1; Zin = 1'b1;
                        ADD  = (opcode == OP_ADDI);
                        AND  = (opcode == OP_ANDI);
                        OR   = (opcode == OP_ORI);
                     end
                     T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_LD, OP_LDI, OP_ST: begin
                  // The three memory forms share the effective-address steps
                  // T3-T4; ldi writes the sum straight back in T5.
                  case (state)
                     T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                     T4: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                     T5: begin
                        Zlowout = 1'b1;
                        if (opcode == OP_LDI) begin
                           Gra = 1'b1; Rin = 1'b1;
                        end else begin
                           MARin = 1'b1;
                        end
                     end
                     T6: begin
                        MDRin = 1'b1;
                        if (opcode == OP_ST) begin
                           Gra = 1'b1; Rout = 1'b1;
                        end else begin
                           Read = 1'b1;
                        end
                     end
                     T7: begin
                        if (opcode == OP_ST) begin
                           Write = 1'b1;
                        end else begin
                           MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (state)
                     T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                     T4: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        MUL = (opcode == OP_MUL);
                        DIV = (opcode == OP_DIV);
                     end
                     T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                     T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  case (state)
                     T3: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        NEG = (opcode == OP_NEG);
                        NOT = (opcode == OP_NOT);
                     end
                     T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_BR: begin
                  case (state)
                     T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                     T4: begin PCout = 1'b1; Yin = 1'b1; end
                     T5: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                     T6: begin Zlowout = CON_FF; PCin = CON_FF; end
                     default: ;
                  endcase
               end
               OP_JR: begin
                  if (state == T3) begin
                     Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                  end
               end
               OP_JAL: begin
                  case (state)
                     T3: begin PCout = 1'b1; R15in = 1'b1; end
                     T4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                     default: ;
                  endcase
               end
               OP_IN: begin
                  if (state == T3) begin
                     InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                  end
               end
               OP_OUT: begin
                  if (state == T3) begin
                     Gra = 1'b1; Rout = 1'b1; OutPortIn = 1'b1;
                  end
               end
               OP_MFHI: begin
                  if (state == T3) begin
                     HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                  end
               end
               OP_MFLO: begin
                  if (state == T3) begin
                     LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                  end
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Directed scoreboard bench for control_unit. The stimulus process drives
// one step per clock and queues the hand-derived control word expected for
// that step; an independent monitor pops and compares on each falling edge.
// ----------------------------------------------------------------------------
module tb_control_unit;

   logic        Clock;
   logic        Clear;
   logic [31:0] IR;
   logic        CON_FF;
   logic        Stop;
   logic        Run, PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout;
   logic        BAout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
   logic        CONin, OutPortIn, R15in, Gra, Grb, Grc, Rin, Rout;
   logic        IncPC, Read, Write;
   logic        ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, MUL, DIV, NEG, NOT;

   logic [41:0] dut_vec;

   typedef struct {
      logic [41:0] vec;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_fail;

   localparam logic [41:0] M_RUN       = 42'd1 << 0;
   localparam logic [41:0] M_PCOUT     = 42'd1 << 1;
   localparam logic [41:0] M_ZLOWOUT   = 42'd1 << 2;
   localparam logic [41:0] M_ZHIGHOUT  = 42'd1 << 3;
   localparam logic [41:0] M_MDROUT    = 42'd1 << 4;
   localparam logic [41:0] M_HIOUT     = 42'd1 << 5;
   localparam logic [41:0] M_LOOUT     = 42'd1 << 6;
   localparam logic [41:0] M_INPORTOUT = 42'd1 << 7;
   localparam logic [41:0] M_BAOUT     = 42'd1 << 8;
   localparam logic [41:0] M_COUT      = 42'd1 << 9;
   localparam logic [41:0] M_MARIN     = 42'd1 << 10;
   localparam logic [41:0] M_ZIN       = 42'd1 << 11;
   localparam logic [41:0] M_PCIN      = 42'd1 << 12;
   localparam logic [41:0] M_MDRIN     = 42'd1 << 13;
   localparam logic [41:0] M_IRIN      = 42'd1 << 14;
   localparam logic [41:0] M_YIN       = 42'd1 << 15;
   localparam logic [41:0] M_LOIN      = 42'd1 << 16;
   localparam logic [41:0] M_HIIN      = 42'd1 << 17;
   localparam logic [41:0] M_CONIN     = 42'd1 << 18;
   localparam logic [41:0] M_OUTPORTIN = 42'd1 << 19;
   localparam logic [41:0] M_R15IN     = 42'd1 << 20;
   localparam logic [41:0] M_GRA       = 42'd1 << 21;
   localparam logic [41:0] M_GRB       = 42'd1 << 22;
   localparam logic [41:0] M_GRC       = 42'd1 << 23;
   localparam logic [41:0] M_RIN       = 42'd1 << 24;
   localparam logic [41:0] M_ROUT      = 42'd1 << 25;
   localparam logic [41:0] M_INCPC     = 42'd1 << 26;
   localparam logic [41:0] M_READ      = 42'd1 << 27;
   localparam logic [41:0] M_WRITE     = 42'd1 << 28;
   localparam logic [41:0] M_ADD       = 42'd1 << 29;
   localparam logic [41:0] M_MUL       = 42'd1 << 38;
   localparam logic [41:0] M_NEG       = 42'd1 << 40;

   localparam logic [41:0] F0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
   localparam logic [41:0] F1 = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
   localparam logic [41:0] F2 = M_RUN | M_MDROUT | M_IRIN;
   localparam logic [41:0] NONE = 42'd0;

   localparam logic [31:0] IR_ADD  = 32'h18918000;
   localparam logic [31:0] IR_LD   = 32'h00800000;
   localparam logic [31:0] IR_LDI  = 32'h08000000;
   localparam logic [31:0] IR_ST   = 32'h10000000;
   localparam logic [31:0] IR_MUL  = 32'h78000000;
   localparam logic [31:0] IR_BR   = 32'h98000000;
   localparam logic [31:0] IR_NEG  = 32'h88000000;
   localparam logic [31:0] IR_JAL  = 32'hA8000000;
   localparam logic [31:0] IR_NOP  = 32'hD0000000;
   localparam logic [31:0] IR_HALT = 32'hD8000000;
   localparam logic [31:0] IR_UNDF = 32'hF8000000;

   assign dut_vec = {NOT, NEG, DIV, MUL, ROL, ROR, SHL, SHRA, SHR, OR, AND,
                     SUB, ADD, Write, Read, IncPC, Rout, Rin, Grc, Grb, Gra,
                     R15in, OutPortIn, CONin, HIin, LOin, Yin, IRin, MDRin,
                     PCin, Zin, MARin, Cout, BAout, InPortout, LOout, HIout,
                     MDRout, Zhighout, Zlowout, PCout, Run};

   control_unit #(.OPW(5)) dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
      .Run(Run), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout),
      .MDRout(MDRout), .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
      .BAout(BAout), .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
      .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin),
      .CONin(CONin), .OutPortIn(OutPortIn), .R15in(R15in), .Gra(Gra),
      .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .IncPC(IncPC),
      .Read(Read), .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
      .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .MUL(MUL),
      .DIV(DIV), .NEG(NEG), .NOT(NOT)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Compare one queued expectation against the live control word.
   task automatic checkOutput(input exp_t e);
      n_checks++;
      if (dut_vec !== e.vec) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", e.name, $time, dut_vec, e.vec);
      end
   endtask

   // Drive one step's inputs just after the rising edge and queue what the
   // control word must look like for that step.
   task automatic applyStimulus(input logic [31:0] ir, input logic con,
                                input logic stop, input logic clr,
                                input logic [41:0] expv, input string name);
      exp_t e;
      @(posedge Clock);
      #1;
      IR     = ir;
      CON_FF = con;
      Stop   = stop;
      Clear  = clr;
      e.vec  = expv;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic fetch(input logic [31:0] ir, input logic con, input string tag);
      applyStimulus(ir, con, 1'b0, 1'b0, F0, {tag, " T0"});
      applyStimulus(ir, con, 1'b0, 1'b0, F1, {tag, " T1"});
      applyStimulus(ir, con, 1'b0, 1'b0, F2, {tag, " T2"});
   endtask

   // Monitor: consumes the scoreboard away from the active edge.
   always @(negedge Clock) begin
      if (exp_q.size() != 0)
         checkOutput(exp_q.pop_front());
   end

   // Hard time limit so the run always ends.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      Clear    = 1'b1;
      IR       = 32'h0;
      CON_FF   = 1'b0;
      Stop     = 1'b0;

      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b1, NONE, "reset held");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, NONE, "rst after release");

      fetch(IR_ADD, 1'b0, "add");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN, "add T3");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, M_RUN | M_GRC | M_ROUT | M_ADD | M_ZIN, "add T4");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "add T5");

      fetch(IR_LD, 1'b0, "ld");
      applyStimulus(IR_LD, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN, "ld T3");
      applyStimulus(IR_LD, 1'b0, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "ld T4");
      applyStimulus(IR_LD, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN, "ld T5");
      applyStimulus(IR_LD, 1'b0, 1'b0, 1'b0, M_RUN | M_READ | M_MDRIN, "ld T6");
      applyStimulus(IR_LD, 1'b0, 1'b0, 1'b0, M_RUN | M_MDROUT | M_GRA | M_RIN, "ld T7");

      fetch(IR_LDI, 1'b0, "ldi");
      applyStimulus(IR_LDI, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN, "ldi T3");
      applyStimulus(IR_LDI, 1'b0, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "ldi T4");
      applyStimulus(IR_LDI, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "ldi T5");

      fetch(IR_ST, 1'b0, "st");
      applyStimulus(IR_ST, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_BAOUT | M_YIN, "st T3");
      applyStimulus(IR_ST, 1'b0, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "st T4");
      applyStimulus(IR_ST, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_MARIN, "st T5");
      applyStimulus(IR_ST, 1'b0, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_MDRIN, "st T6");
      applyStimulus(IR_ST, 1'b0, 1'b0, 1'b0, M_RUN | M_WRITE, "st T7");

      fetch(IR_MUL, 1'b0, "mul");
      applyStimulus(IR_MUL, 1'b0, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_YIN, "mul T3");
      applyStimulus(IR_MUL, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_MUL | M_ZIN, "mul T4");
      applyStimulus(IR_MUL, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_LOIN, "mul T5");
      applyStimulus(IR_MUL, 1'b0, 1'b0, 1'b0, M_RUN | M_ZHIGHOUT | M_HIIN, "mul T6");

      fetch(IR_BR, 1'b0, "br0");
      applyStimulus(IR_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_CONIN, "br0 T3");
      applyStimulus(IR_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_PCOUT | M_YIN, "br0 T4");
      applyStimulus(IR_BR, 1'b0, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "br0 T5");
      applyStimulus(IR_BR, 1'b0, 1'b0, 1'b0, M_RUN, "br0 T6 not taken");

      fetch(IR_BR, 1'b1, "br1");
      applyStimulus(IR_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_CONIN, "br1 T3");
      applyStimulus(IR_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_PCOUT | M_YIN, "br1 T4");
      applyStimulus(IR_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_COUT | M_ADD | M_ZIN, "br1 T5");
      applyStimulus(IR_BR, 1'b1, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_PCIN, "br1 T6 taken");

      fetch(IR_NEG, 1'b0, "neg");
      applyStimulus(IR_NEG, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_NEG | M_ZIN, "neg T3");
      applyStimulus(IR_NEG, 1'b0, 1'b0, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "neg T4");

      fetch(IR_JAL, 1'b0, "jal");
      applyStimulus(IR_JAL, 1'b0, 1'b0, 1'b0, M_RUN | M_PCOUT | M_R15IN, "jal T3");
      applyStimulus(IR_JAL, 1'b0, 1'b0, 1'b0, M_RUN | M_GRA | M_ROUT | M_PCIN, "jal T4");

      fetch(IR_NOP, 1'b0, "nop");
      fetch(IR_UNDF, 1'b0, "undef");

      // Clear asserted just after entering T4 of add.
      fetch(IR_ADD, 1'b0, "clr add");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN, "clr add T3");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b1, NONE, "clear mid T4");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, NONE, "rst after mid clear");

      // Stop raised during T3 of add: add completes, then HALT.
      fetch(IR_ADD, 1'b0, "stop add");
      applyStimulus(IR_ADD, 1'b0, 1'b1, 1'b0, M_RUN | M_GRB | M_ROUT | M_YIN, "stop add T3");
      applyStimulus(IR_ADD, 1'b0, 1'b1, 1'b0, M_RUN | M_GRC | M_ROUT | M_ADD | M_ZIN, "stop add T4");
      applyStimulus(IR_ADD, 1'b0, 1'b1, 1'b0, M_RUN | M_ZLOWOUT | M_GRA | M_RIN, "stop add T5");
      for (int i = 0; i < 10; i++)
         applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, NONE, "halt after stop");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b1, NONE, "clear from halt");
      applyStimulus(IR_HALT, 1'b0, 1'b0, 1'b0, NONE, "rst before halt op");

      // halt opcode leaves fetch for HALT.
      fetch(IR_HALT, 1'b0, "halt op");
      for (int i = 0; i < 10; i++)
         applyStimulus(IR_HALT, 1'b0, 1'b0, 1'b0, NONE, "halt op held");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b1, NONE, "clear from halt op");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, NONE, "rst final");
      applyStimulus(IR_ADD, 1'b0, 1'b0, 1'b0, F0, "final T0");

      // Let the monitor drain, bounded.
      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(negedge Clock);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      @(posedge Clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
